// File: rtl/tx_msg_sequencer.sv
// Buffered multi-word feeder for the UART transmitter; inter-word GAP state enabled by `TXSEQ_GAP_EN.
// Latency: start sampled at edge N -> TxData after edge N+1 -> XMitGo high after edge N+2.
// Backpressure: each word waits for TxEmpty to fall (accepted) and rise (finished) before the next load.
module tx_msg_sequencer #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              start,
  input  logic              repeat_mode,
  input  logic              abort,
  input  logic              TxEmpty,
  output logic [DATA_W-1:0] TxData,
  output logic              XMitGo,
  output logic              busy,
  output logic              done,
  output logic [2:0]        OutState
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    GO         = 3'd2,
    WAIT_ACK   = 3'd3,
    WAIT_EMPTY = 3'd4,
    GAP        = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

`ifdef TXSEQ_GAP_EN
  localparam state_t AFTER_WORD = GAP;
  logic [7:0] gapCnt;
`else
  localparam state_t AFTER_WORD = LOAD;
`endif

  logic [DATA_W-1:0] msgBuf [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] wordIdx;
  logic [ADDR_W-1:0] lastIdx;
  logic              rpt;
  logic [ADDR_W:0]   clampLen;
  logic              lastWord;

  // Buffer is deliberately left out of reset so a message survives a reset.
  always_ff @(posedge clk) begin
    if (wr_en) msgBuf[wr_addr] <= wr_data;
  end

  assign clampLen = (msg_len > DEPTH_LEN) ? DEPTH_LEN : msg_len;
  assign lastWord = (wordIdx == lastIdx);

  // Outputs are registered images of the state being left, hence one clock behind state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wordIdx  <= '0;
      lastIdx  <= '0;
      rpt      <= 1'b0;
      TxData   <= '0;
      XMitGo   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      OutState <= '0;
`ifdef TXSEQ_GAP_EN
      gapCnt   <= '0;
`endif
    end else begin
      OutState <= state;
      busy     <= (state != IDLE);
      XMitGo   <= 1'b0;
      done     <= 1'b0;
      if (abort && (state != IDLE)) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && (msg_len != '0)) begin
              state   <= LOAD;
              wordIdx <= '0;
              lastIdx <= ADDR_W'(clampLen - 1'b1);
              rpt     <= repeat_mode;
            end
          end
          LOAD: begin
            TxData <= msgBuf[wordIdx];
            state  <= GO;
          end
          GO: begin
            XMitGo <= 1'b1;
            state  <= WAIT_ACK;
          end
          WAIT_ACK: begin
            if (!TxEmpty) state <= WAIT_EMPTY;
          end
          WAIT_EMPTY: begin
            if (TxEmpty) begin
              if (lastWord) begin
                done    <= 1'b1;
                wordIdx <= '0;
              end else begin
                wordIdx <= wordIdx + 1'b1;
              end
              if (lastWord && !rpt) begin
                state <= IDLE;
              end else begin
                state <= AFTER_WORD;
`ifdef TXSEQ_GAP_EN
                gapCnt <= 8'(GAP_CYCLES);
`endif
              end
            end
          end
`ifdef TXSEQ_GAP_EN
          GAP: begin
            if (gapCnt == 8'd1) state <= LOAD;
            else gapCnt <= gapCnt - 1'b1;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
